// File: rtl/keccak_pad_pkg.sv
// Shared definitions for the Keccak/SHA-3 multi-rate padder.
// Contents: mode encoding, suffix/pad byte constants, the mode -> suffix
// mapping, and the padder FSM state type.
package keccak_pad_pkg;

    typedef enum logic [1:0] {
        MODE_KECCAK   = 2'b00,
        MODE_SHA3     = 2'b01,
        MODE_SHAKE    = 2'b10,
        MODE_SHA3_ALT = 2'b11
    } pad_mode_t;

    localparam logic [7:0] SFX_KECCAK = 8'h01;
    localparam logic [7:0] SFX_SHA3   = 8'h06;
    localparam logic [7:0] SFX_SHAKE  = 8'h1F;
    localparam logic [7:0] PAD_END    = 8'h80;

    typedef enum logic [1:0] {
        ST_FILL = 2'b00,
        ST_PAD  = 2'b01,
        ST_FULL = 2'b10
    } pad_state_t;

    // Encoding 11 is unassigned and falls back to the SHA-3 suffix.
    function automatic logic [7:0] mode_suffix(input pad_mode_t mode);
        case (mode)
            MODE_KECCAK: return SFX_KECCAK;
            MODE_SHAKE:  return SFX_SHAKE;
            default:     return SFX_SHA3;
        endcase
    endfunction

endpackage

// File: rtl/keccak_pad_word.sv
// Combinational builder for the last message word of a padded block.
// Ports:
//   in           - raw message word, first byte in the MSB byte
//   byte_num     - number of valid message bytes (0..NB-1)
//   suffix       - domain-separation suffix byte
//   is_final_pos - word lands in the last slot of the block; OR 0x80 into LSB
//   word         - padded word: kept bytes, suffix, zero bytes
import keccak_pad_pkg::*;

module keccak_pad_word #(
    parameter int unsigned IN_W = 32,
    parameter int unsigned NB   = IN_W / 8,
    parameter int unsigned BN_W = $clog2(NB)
) (
    input  logic [IN_W-1:0] in,
    input  logic [BN_W-1:0] byte_num,
    input  logic [7:0]      suffix,
    input  logic            is_final_pos,
    output logic [IN_W-1:0] word
);

    always_comb begin
        word = '0;
        // Byte k counts from the MSB end, matching message byte order.
        for (int unsigned k = 0; k < NB; k++) begin
            if (BN_W'(k) < byte_num)
                word[IN_W-1-8*k -: 8] = in[IN_W-1-8*k -: 8];
            else if (BN_W'(k) == byte_num)
                word[IN_W-1-8*k -: 8] = suffix;
        end
        if (is_final_pos)
            word[7:0] = word[7:0] | PAD_END;
    end

endmodule

// File: rtl/keccak_padder_multi.sv
// Keccak/SHA-3 input padder and rate-block buffer with back-to-back messages.
// Ports:
//   clk, reset_n          - clock, synchronous active-low reset
//   in, in_ready          - message word stream (first byte in MSB byte)
//   is_last, byte_num     - end-of-message marker and valid byte count
//   mode                  - suffix select (Keccak / SHA-3 / SHAKE)
//   buffer_full,out_ready - block held, input stalled
//   out                   - RATE-bit block, word 0 at the top
//   last_block            - held block is the final (padded) block
//   f_ack                 - consumer takes the held block
import keccak_pad_pkg::*;

module keccak_padder_multi #(
    parameter  int unsigned IN_W  = 32,
    parameter  int unsigned RATE  = 576,
    localparam int unsigned WORDS = RATE / IN_W,
    localparam int unsigned NB    = IN_W / 8,
    localparam int unsigned BN_W  = $clog2(NB)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [IN_W-1:0] in,
    input  logic            in_ready,
    input  logic            is_last,
    input  logic [BN_W-1:0] byte_num,
    input  logic [1:0]      mode,
    output logic            buffer_full,
    output logic [RATE-1:0] out,
    output logic            out_ready,
    output logic            last_block,
    input  logic            f_ack
);

    localparam int unsigned   CNT_W    = $clog2(WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

    pad_state_t       state;
    logic [CNT_W-1:0] count;
    logic             final_pos;
    logic [7:0]       suffix;
    logic [IN_W-1:0]  padded;
    logic [IN_W-1:0]  w;

    assign final_pos = (count == LAST_IDX);
    assign suffix    = mode_suffix(pad_mode_t'(mode));
    assign out_ready = buffer_full;

    keccak_pad_word #(
        .IN_W(IN_W)
    ) u_pad_word (
        .in          (in),
        .byte_num    (byte_num),
        .suffix      (suffix),
        .is_final_pos(final_pos),
        .word        (padded)
    );

    // Word shifted in this cycle: message word, padded last word, or filler.
    always_comb begin
        w = '0;
        case (state)
            ST_FILL: w = is_last ? padded : in;
            ST_PAD:  if (final_pos) w[7:0] = PAD_END;
            default: w = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_FILL;
            count       <= '0;
            out         <= '0;
            buffer_full <= 1'b0;
            last_block  <= 1'b0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (in_ready) begin
                        out   <= {out[RATE-IN_W-1:0], w};
                        count <= count + CNT_W'(1);
                        if (final_pos) begin
                            // Last word in the last slot already carries the
                            // pad end, so no PAD pass is needed.
                            state       <= ST_FULL;
                            buffer_full <= 1'b1;
                            last_block  <= is_last;
                        end else if (is_last) begin
                            state <= ST_PAD;
                        end
                    end
                end
                ST_PAD: begin
                    out   <= {out[RATE-IN_W-1:0], w};
                    count <= count + CNT_W'(1);
                    if (final_pos) begin
                        state       <= ST_FULL;
                        buffer_full <= 1'b1;
                        last_block  <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (f_ack) begin
                        state       <= ST_FILL;
                        count       <= '0;
                        out         <= '0;
                        buffer_full <= 1'b0;
                        last_block  <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_FILL;
                    count       <= '0;
                    out         <= '0;
                    buffer_full <= 1'b0;
                    last_block  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_padder_multi.sv
module tb_keccak_padder_multi;

    localparam int IN_W  = 32;
    localparam int RATE  = 576;
    localparam int WORDS = 18;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [IN_W-1:0] in_w;
    logic            in_ready;
    logic            is_last;
    logic [1:0]      byte_num;
    logic [1:0]      mode;
    logic            buffer_full;
    logic [RATE-1:0] out;
    logic            out_ready;
    logic            last_block;
    logic            f_ack;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_w [WORDS];

    keccak_padder_multi #(
        .IN_W(IN_W),
        .RATE(RATE)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in         (in_w),
        .in_ready   (in_ready),
        .is_last    (is_last),
        .byte_num   (byte_num),
        .mode       (mode),
        .buffer_full(buffer_full),
        .out        (out),
        .out_ready  (out_ready),
        .last_block (last_block),
        .f_ack      (f_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [RATE-1:0] exp_block();
        logic [RATE-1:0] r;
        r = '0;
        for (int i = 0; i < WORDS; i++)
            r[RATE-1-32*i -: 32] = exp_w[i];
        return r;
    endfunction

    task automatic clear_exp();
        for (int i = 0; i < WORDS; i++) exp_w[i] = '0;
    endtask

    task automatic send(input logic [31:0] w, input logic last,
                        input logic [1:0] bn, input logic [1:0] md);
        in_w     = w;
        in_ready = 1'b1;
        is_last  = last;
        byte_num = bn;
        mode     = md;
        @(posedge clk); #1;
        in_ready = 1'b0;
        is_last  = 1'b0;
        byte_num = '0;
        mode     = '0;
    endtask

    // Latency in cycles from the last accepting edge to out_ready high.
    task automatic wait_full(output int lat);
        lat = 1;
        while (!out_ready && lat <= 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic ack();
        f_ack = 1'b1;
        @(posedge clk); #1;
        f_ack = 1'b0;
    endtask

    task automatic send_hello();
        send(32'h48656c6c, 1'b0, 2'd0, 2'b00);
        send(32'h6f2c2077, 1'b0, 2'd0, 2'b00);
        send(32'h6f726c64, 1'b0, 2'd0, 2'b00);
        send(32'h21202020, 1'b1, 2'd1, 2'b00);
    endtask

    task automatic set_hello_exp();
        clear_exp();
        exp_w[0]  = 32'h48656c6c;
        exp_w[1]  = 32'h6f2c2077;
        exp_w[2]  = 32'h6f726c64;
        exp_w[3]  = 32'h21010000;
        exp_w[17] = 32'h00000080;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (buffer_full !== 1'b0 || out_ready !== 1'b0 || last_block !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: got bf=%b or=%b lb=%b, want 0 0 0",
                     buffer_full, out_ready, last_block);
        end
        checks++;
        if (out !== '0) begin
            failures++;
            $display("FAIL reset_out: got %h, want 0", out);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_keccak_pad();
        int lat;
        set_hello_exp();
        send_hello();
        wait_full(lat);
        checks++;
        if (lat !== 15) begin
            failures++;
            $display("FAIL keccak_latency: got %0d, want 15", lat);
        end
        checks++;
        if (out !== exp_block()) begin
            failures++;
            $display("FAIL keccak_block: got %h want %h", out, exp_block());
        end
        checks++;
        if (last_block !== 1'b1) begin
            failures++;
            $display("FAIL keccak_last_block: got %b, want 1", last_block);
        end
        ack();
        checks++;
        if (buffer_full !== 1'b0 || last_block !== 1'b0 || out !== '0) begin
            failures++;
            $display("FAIL keccak_ack_clear: got bf=%b lb=%b out_nonzero=%b, want 0 0 0",
                     buffer_full, last_block, |out);
        end
    endtask

    task automatic test_merged_end();
        int lat;
        // SHA-3 with three message bytes: suffix lands in the LSB byte.
        clear_exp();
        for (int i = 0; i < 17; i++) begin
            exp_w[i] = 32'hA5A50000 | 32'(i);
            send(exp_w[i], 1'b0, 2'd0, 2'b00);
        end
        send(32'h61626320, 1'b1, 2'd3, 2'b01);
        exp_w[17] = 32'h61626386;
        wait_full(lat);
        checks++;
        if (lat !== 1) begin
            failures++;
            $display("FAIL merged_latency: got %0d, want 1", lat);
        end
        checks++;
        if (out !== exp_block() || last_block !== 1'b1) begin
            failures++;
            $display("FAIL merged_sha3_block: got lb=%b %h want lb=1 %h",
                     last_block, out, exp_block());
        end
        ack();
        // SHAKE with zero message bytes in the last slot; input bytes dropped.
        clear_exp();
        for (int i = 0; i < 17; i++) begin
            exp_w[i] = 32'h5A5A0000 | 32'(i);
            send(exp_w[i], 1'b0, 2'd0, 2'b00);
        end
        send(32'hFFFFFFFF, 1'b1, 2'd0, 2'b10);
        exp_w[17] = 32'h1F000080;
        wait_full(lat);
        checks++;
        if (lat !== 1 || out !== exp_block()) begin
            failures++;
            $display("FAIL merged_shake_block: got lat=%0d %h want lat=1 %h",
                     lat, out, exp_block());
        end
        ack();
    endtask

    task automatic test_multi_block();
        int lat;
        logic [RATE-1:0] held;
        logic [RATE-1:0] one;
        clear_exp();
        for (int i = 0; i < WORDS; i++) begin
            exp_w[i] = 32'h10000000 + 32'(i);
            send(exp_w[i], 1'b0, 2'd0, 2'b00);
        end
        wait_full(lat);
        checks++;
        if (lat !== 1 || buffer_full !== 1'b1 || last_block !== 1'b0) begin
            failures++;
            $display("FAIL multi_full: got lat=%0d bf=%b lb=%b, want 1 1 0",
                     lat, buffer_full, last_block);
        end
        checks++;
        if (out !== exp_block()) begin
            failures++;
            $display("FAIL multi_block: got %h want %h", out, exp_block());
        end
        held     = out;
        in_w     = 32'hDEADBEEF;
        in_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (buffer_full !== 1'b1 || out !== exp_block()) begin
            failures++;
            $display("FAIL multi_stall: got bf=%b %h want bf=1 %h",
                     buffer_full, out, exp_block());
        end
        f_ack = 1'b1;
        @(posedge clk); #1;
        f_ack = 1'b0;
        checks++;
        if (buffer_full !== 1'b0 || out !== '0) begin
            failures++;
            $display("FAIL multi_ack_no_accept: got bf=%b %h, want bf=0 0",
                     buffer_full, out);
        end
        @(posedge clk); #1;
        in_ready = 1'b0;
        one = '0;
        one[31:0] = 32'hDEADBEEF;
        checks++;
        if (out !== one) begin
            failures++;
            $display("FAIL multi_held_word: got %h want %h", out, one);
        end
        // Terminate on a word boundary: is_last with byte_num=0 at index 1.
        send(32'h11223344, 1'b1, 2'd0, 2'b00);
        clear_exp();
        exp_w[0]  = 32'hDEADBEEF;
        exp_w[1]  = 32'h01000000;
        exp_w[17] = 32'h00000080;
        wait_full(lat);
        checks++;
        if (lat !== 17 || out !== exp_block() || last_block !== 1'b1) begin
            failures++;
            $display("FAIL multi_second_block: got lat=%0d lb=%b %h want lat=17 lb=1 %h (prev %h)",
                     lat, last_block, out, exp_block(), held[31:0]);
        end
        ack();
    endtask

    task automatic test_back_to_back();
        int lat;
        send(32'h41424344, 1'b1, 2'd2, 2'b10);
        clear_exp();
        exp_w[0]  = 32'h41421F00;
        exp_w[17] = 32'h00000080;
        wait_full(lat);
        checks++;
        if (lat !== 18 || out !== exp_block() || last_block !== 1'b1) begin
            failures++;
            $display("FAIL b2b_shake: got lat=%0d lb=%b %h want lat=18 lb=1 %h",
                     lat, last_block, out, exp_block());
        end
        ack();
        send(32'h55667788, 1'b1, 2'd0, 2'b11);
        clear_exp();
        exp_w[0]  = 32'h06000000;
        exp_w[17] = 32'h00000080;
        wait_full(lat);
        checks++;
        if (lat !== 18 || out !== exp_block() || last_block !== 1'b1) begin
            failures++;
            $display("FAIL b2b_mode11: got lat=%0d lb=%b %h want lat=18 lb=1 %h",
                     lat, last_block, out, exp_block());
        end
        ack();
        checks++;
        if (buffer_full !== 1'b0) begin
            failures++;
            $display("FAIL b2b_final_ack: got bf=%b, want 0", buffer_full);
        end
    endtask

    task automatic test_reset_mid_fill();
        int lat;
        logic [RATE-1:0] part;
        part = '0;
        for (int i = 0; i < 5; i++) begin
            send(32'hCAFE0000 | 32'(i), 1'b0, 2'd0, 2'b00);
            part[32*(4-i) +: 32] = 32'hCAFE0000 | 32'(i);
        end
        ack();
        checks++;
        if (out !== part || buffer_full !== 1'b0) begin
            failures++;
            $display("FAIL fill_ack_ignored: got bf=%b %h want bf=0 %h",
                     buffer_full, out, part);
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        checks++;
        if (out !== '0 || buffer_full !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_clear: got bf=%b %h, want bf=0 0", buffer_full, out);
        end
        set_hello_exp();
        send_hello();
        wait_full(lat);
        checks++;
        if (lat !== 15 || out !== exp_block() || last_block !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_hello: got lat=%0d lb=%b %h want lat=15 lb=1 %h",
                     lat, last_block, out, exp_block());
        end
        ack();
    endtask

    initial begin
        reset_n  = 1'b0;
        in_w     = '0;
        in_ready = 1'b0;
        is_last  = 1'b0;
        byte_num = '0;
        mode     = '0;
        f_ack    = 1'b0;
        test_reset();
        test_keccak_pad();
        test_merged_end();
        test_multi_block();
        test_back_to_back();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keccak_padder_multi.md
# keccak_padder_multi

Parametrised Keccak/SHA-3 input padder and rate-block buffer. It accepts a byte-aligned message as a stream of IN_W-bit words and applies multi-rate padding with a run-time selectable domain-separation suffix (Keccak, SHA-3 or SHAKE). It emits one RATE-bit block per permutation call, with a final-block marker. It sits between the host word stream and the f-permutation core. Unlike the fixed 32-bit/576-bit padder, consecutive messages can run back-to-back without a reset.

## Interface
- IN_W, 32: input word width; legal values are 32 and 64.
- RATE, 576: block width in bits; must be a multiple of IN_W (576, 832, 1088, 1152, 1344).
- Derived: WORDS = RATE/IN_W; NB = IN_W/8; BN_W = log2(NB).

Ports:
- clk  in  1  clock, all logic on the rising edge
- reset_n  in  1  synchronous, active-low reset
- in  in  IN_W  message word; the first message byte is in the MSB byte
- in_ready  in  1  `in` is valid this cycle
- is_last  in  1  this word ends the message
- byte_num  in  BN_W  number of valid bytes in the last word, 0..NB-1
- mode  in  2  padding suffix: 00 = Keccak 0x01, 01 = SHA-3 0x06, 10 = SHAKE 0x1F, 11 = treated as 01
- buffer_full  out  1  block holds WORDS words; no input is accepted
- out  out  RATE  assembled block; word 0 is at out[RATE-1 -: IN_W]
- out_ready  out  1  out is valid (equal to buffer_full)
- last_block  out  1  the block in out is the final block of its message
- f_ack  in  1  consumer takes the block this cycle

## Operation
- States: FILL (accepting words), PAD (appending zero words), FULL (block held).
- accept = in_ready && state==FILL. Words shift in: out <= {out[RATE-IN_W-1:0], w}; count increments.
- Non-last word: w = in. A full message ending on a word boundary is terminated by a word with is_last=1, byte_num=0.
- Last word: w = top byte_num bytes of in, then the suffix byte for `mode`, then zero bytes. `mode` is sampled only on this word.
- Final-byte rule: if the last word lands at index WORDS-1, its LSB byte is ORed with 0x80; e.g. byte_num=3 with SHA-3 gives LSB 0x86.
  - Otherwise the FSM enters PAD and appends one zero word per cycle. The word at index WORDS-1 is 0x80 in its LSB byte.
- Because byte_num ≤ NB-1, the suffix always fits in the last word, so padding never spills into an extra block.
- count reaching WORDS moves the FSM to FULL: buffer_full=out_ready=1.
  - last_block=1 if the block includes padding, else 0.
- FULL with f_ack=1: the next cycle gives out=0, count=0, buffer_full=0, last_block=0, state FILL.
  - Both message-continuation blocks and final blocks return to FILL; the next message starts without a reset.
- in_ready while in PAD or FULL: the word is ignored and not consumed. The host holds it until buffer_full falls.
- f_ack while not FULL: ignored.
- Reset (reset_n=0 at an edge): out=0, count=0, buffer_full=0, out_ready=0, last_block=0, state FILL. Any partial block is discarded regardless of state.

## Timing
- One word per cycle maximum; acceptance occurs at the edge where accept=1.
- buffer_full rises the cycle after the WORDS-th word is accepted.
- Last word at index j: out_ready rises WORDS-j cycles after it is accepted (1 cycle if j=WORDS-1).
- f_ack to buffer_full low: 1 cycle. The earliest next accept is the following edge, because in_ready in the f_ack cycle is not accepted.
- Back-to-back throughput: WORDS+1 cycles per block.
- reset_n has priority over every other input in the same cycle.

## Structure
- Package keccak_pad_pkg holds:
  - the mode encoding type;
  - suffix constants SFX_KECCAK=8'h01, SFX_SHA3=8'h06, SFX_SHAKE=8'h1F, and PAD_END=8'h80;
  - a function mapping mode to its suffix byte;
  - the state enum.
- Sub-module keccak_pad_word is combinational. Given in, byte_num, the suffix byte and an is_final_pos flag, it produces the padded word. The top level holds the FSM, counter and shift register.

## Test plan
All scenarios use IN_W=32 and RATE=576 (WORDS=18).
- Reset: hold reset_n=0 for 2 cycles -> buffer_full=0, out_ready=0, last_block=0, out=0.
- Keccak pad: send "Hell", "o, w", "orld", then "!   " with byte_num=1, is_last=1, mode=00.
  - out_ready rises 15 cycles later; word 3 = 0x21010000, words 4..16 = 0, word 17 = 0x00000080, last_block=1.
- Merged end byte: send 17 full words, then "abc " with byte_num=3, is_last=1, mode=01.
  - Word 17 = 0x61626386; out_ready rises 1 cycle after.
- Multi-block: send 18 full words with is_last=0.
  - buffer_full=1 and last_block=0; in_ready held high is not accepted.
  - Assert f_ack; the held word is accepted 2 edges later as word 0 of the next block.
- Back-to-back messages: ack a final block, then send a new message immediately with no reset.
  - The second block is correct and last_block=1 again. Repeat with mode=10: suffix byte 0x1F.
- Reset mid-fill: after 5 accepted words, pulse reset_n.
  - count=0 and out=0; a following "Hell"/"o, w"/"orld"/"!   " message yields the same block as the Keccak pad scenario.
